// File: rtl/mac_seq_ctrl.sv
// Sequencer for a single mul_core MAC unit: computes y = W*x one row at a time,
// streaming node/weight pairs into the core and writing each accumulation to result memory.
module mac_seq_ctrl #(
  parameter int unsigned IN_DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH    = 10,
  parameter int unsigned CNT_WIDTH     = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       i_start,
  input  logic [CNT_WIDTH-1:0]       i_num_k,
  input  logic [CNT_WIDTH-1:0]       i_num_m,
  output logic                       o_idle,
  output logic                       o_running,
  output logic                       o_done,
  output logic                       o_node_ce,
  output logic [ADDR_WIDTH-1:0]      o_node_addr,
  output logic                       o_wegt_ce,
  output logic [ADDR_WIDTH-1:0]      o_wegt_addr,
  input  logic [IN_DATA_WIDTH-1:0]   i_node_data,
  input  logic [IN_DATA_WIDTH-1:0]   i_wegt_data,
  output logic                       o_core_run,
  output logic                       o_core_valid,
  output logic [IN_DATA_WIDTH-1:0]   o_core_node,
  output logic [IN_DATA_WIDTH-1:0]   o_core_wegt,
  input  logic                       i_core_valid,
  input  logic [4*IN_DATA_WIDTH-1:0] i_core_result,
  output logic                       o_res_we,
  output logic [CNT_WIDTH-1:0]       o_res_addr,
  output logic [4*IN_DATA_WIDTH-1:0] o_res_data
);

  localparam int unsigned ResWidth = 4 * IN_DATA_WIDTH;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StIssue,
    StWait,
    StWrite,
    StDone
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_WIDTH-1:0]  num_k_q, num_k_d;
  logic [CNT_WIDTH-1:0]  num_m_q, num_m_d;
  logic [CNT_WIDTH-1:0]  k_q, k_d;
  logic [CNT_WIDTH-1:0]  vcnt_q, vcnt_d;
  logic [CNT_WIDTH-1:0]  m_q, m_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [ResWidth-1:0]   result_q, result_d;
  logic                  core_valid_q;

  logic ce;
  logic res_we;
  logic last_valid;

  // The K-th returned valid; num_k_q is nonzero whenever this is consulted.
  assign last_valid = i_core_valid && (vcnt_q == num_k_q - CNT_WIDTH'(1));

  always_comb begin
    state_d    = state_q;
    num_k_d    = num_k_q;
    num_m_d    = num_m_q;
    k_d        = k_q;
    m_d        = m_q;
    ptr_d      = ptr_q;
    result_d   = result_q;
    vcnt_d     = i_core_valid ? vcnt_q + CNT_WIDTH'(1) : vcnt_q;
    ce         = 1'b0;
    res_we     = 1'b0;
    o_core_run = 1'b0;
    o_done     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          num_k_d = i_num_k;
          num_m_d = i_num_m;
          m_d     = '0;
          ptr_d   = '0;
          state_d = StClear;
        end
      end
      StClear: begin
        o_core_run = 1'b1;
        k_d        = '0;
        vcnt_d     = '0;
        state_d    = (num_k_q == '0 || num_m_q == '0) ? StDone : StIssue;
      end
      StIssue: begin
        ce    = 1'b1;
        k_d   = k_q + CNT_WIDTH'(1);
        ptr_d = ptr_q + ADDR_WIDTH'(1);
        if (k_q == num_k_q - CNT_WIDTH'(1)) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (last_valid) begin
          result_d = i_core_result;
          state_d  = StWrite;
        end
      end
      StWrite: begin
        res_we = 1'b1;
        if (m_q == num_m_q - CNT_WIDTH'(1)) begin
          state_d = StDone;
        end else begin
          m_d     = m_q + CNT_WIDTH'(1);
          state_d = StClear;
        end
      end
      StDone: begin
        o_done  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      num_k_q      <= '0;
      num_m_q      <= '0;
      k_q          <= '0;
      vcnt_q       <= '0;
      m_q          <= '0;
      ptr_q        <= '0;
      result_q     <= '0;
      core_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      num_k_q      <= num_k_d;
      num_m_q      <= num_m_d;
      k_q          <= k_d;
      vcnt_q       <= vcnt_d;
      m_q          <= m_d;
      ptr_q        <= ptr_d;
      result_q     <= result_d;
      core_valid_q <= ce;
    end
  end

  assign o_idle       = (state_q == StIdle);
  assign o_running    = ~o_idle;
  assign o_node_ce    = ce;
  assign o_wegt_ce    = ce;
  assign o_node_addr  = ce ? ADDR_WIDTH'(k_q) : '0;
  assign o_wegt_addr  = ce ? ptr_q : '0;
  assign o_core_valid = core_valid_q;
  // Operands are gated so the core inputs read zero outside valid beats.
  assign o_core_node  = core_valid_q ? i_node_data : '0;
  assign o_core_wegt  = core_valid_q ? i_wegt_data : '0;
  assign o_res_we     = res_we;
  assign o_res_addr   = res_we ? m_q : '0;
  assign o_res_data   = result_q;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Scoreboard bench for mac_seq_ctrl with behavioural memories and a 2-cycle MAC core model.
module tb_mac_seq_ctrl;
  localparam int DW = 8;
  localparam int AW = 10;
  localparam int CW = 8;
  localparam int RW = 4 * DW;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          i_start;
  logic [CW-1:0] i_num_k, i_num_m;
  logic          o_idle, o_running, o_done;
  logic          o_node_ce, o_wegt_ce;
  logic [AW-1:0] o_node_addr, o_wegt_addr;
  logic [DW-1:0] i_node_data, i_wegt_data;
  logic          o_core_run, o_core_valid;
  logic [DW-1:0] o_core_node, o_core_wegt;
  logic          i_core_valid;
  logic [RW-1:0] i_core_result;
  logic          o_res_we;
  logic [CW-1:0] o_res_addr;
  logic [RW-1:0] o_res_data;

  always #5 clk = ~clk;

  mac_seq_ctrl #(.IN_DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset_n(reset_n), .i_start(i_start), .i_num_k(i_num_k), .i_num_m(i_num_m),
    .o_idle(o_idle), .o_running(o_running), .o_done(o_done),
    .o_node_ce(o_node_ce), .o_node_addr(o_node_addr),
    .o_wegt_ce(o_wegt_ce), .o_wegt_addr(o_wegt_addr),
    .i_node_data(i_node_data), .i_wegt_data(i_wegt_data),
    .o_core_run(o_core_run), .o_core_valid(o_core_valid),
    .o_core_node(o_core_node), .o_core_wegt(o_core_wegt),
    .i_core_valid(i_core_valid), .i_core_result(i_core_result),
    .o_res_we(o_res_we), .o_res_addr(o_res_addr), .o_res_data(o_res_data)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memories: synchronous read, data one cycle after ce.
  logic [DW-1:0] node_mem [0:1023];
  logic [DW-1:0] wegt_mem [0:1023];
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      i_node_data <= '0;
      i_wegt_data <= '0;
    end else if (o_node_ce) begin
      i_node_data <= node_mem[o_node_addr];
      i_wegt_data <= wegt_mem[o_wegt_addr];
    end
  end

  // Core: accumulate on i_valid, clear on i_run, o_valid two cycles after i_valid.
  logic [RW-1:0] acc;
  logic          v1, v2;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc <= '0;
      v1  <= 1'b0;
      v2  <= 1'b0;
    end else begin
      v1 <= o_core_valid;
      v2 <= v1;
      if (o_core_run) acc <= '0;
      else if (o_core_valid) acc <= acc + RW'(o_core_node) * RW'(o_core_wegt);
    end
  end
  assign i_core_valid  = v2;
  assign i_core_result = acc;

  typedef struct {
    int            cyc;
    int            a;
    int            b;
    logic [RW-1:0] d;
  } exp_t;

  exp_t ce_q[$];
  exp_t wr_q[$];
  int   run_q[$];
  int   done_q[$];

  int            n_chk  = 0;
  int            n_fail = 0;
  logic [RW-1:0] last_wr_data;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    int   c;
    if (reset_n) begin
      if (o_node_ce || o_wegt_ce) begin
        chk("ce pair", 64'(o_wegt_ce), 64'(o_node_ce));
        if (ce_q.size() == 0) fail_now("unexpected ce");
        else begin
          e = ce_q.pop_front();
          chk("ce cycle", 64'(cyc), 64'(e.cyc));
          chk("node addr", 64'(o_node_addr), 64'(e.a));
          chk("wegt addr", 64'(o_wegt_addr), 64'(e.b));
        end
      end
      if (o_core_run) begin
        if (run_q.size() == 0) fail_now("unexpected core_run");
        else begin
          c = run_q.pop_front();
          chk("core_run cycle", 64'(cyc), 64'(c));
        end
      end
      if (o_res_we) begin
        last_wr_data = o_res_data;
        if (wr_q.size() == 0) fail_now("unexpected res_we");
        else begin
          e = wr_q.pop_front();
          chk("write cycle", 64'(cyc), 64'(e.cyc));
          chk("write addr", 64'(o_res_addr), 64'(e.a));
          chk("write data", 64'(o_res_data), 64'(e.d));
        end
      end
      if (o_done) begin
        if (done_q.size() == 0) fail_now("unexpected done");
        else begin
          c = done_q.pop_front();
          chk("done cycle", 64'(cyc), 64'(c));
        end
      end
    end
  end

  // Reference: y[r] = sum_j x[j] * W[r*K + j]; row r occupies K+5 cycles starting at s+1.
  task automatic start_run(input int k, input int m, output int s);
    exp_t e;
    @(negedge clk);
    chk("idle before start", 64'(o_idle), 64'd1);
    i_num_k = CW'(k);
    i_num_m = CW'(m);
    i_start = 1'b1;
    s = cyc;
    if (k == 0 || m == 0) begin
      run_q.push_back(s + 1);
      done_q.push_back(s + 2);
    end else begin
      for (int r = 0; r < m; r++) begin
        run_q.push_back(s + 1 + r * (k + 5));
        e.d = '0;
        for (int j = 0; j < k; j++) begin
          e.cyc = s + 2 + r * (k + 5) + j;
          e.a   = j;
          e.b   = r * k + j;
          ce_q.push_back(e);
          e.d = e.d + RW'(node_mem[j]) * RW'(wegt_mem[r * k + j]);
        end
        e.cyc = s + (r + 1) * (k + 5);
        e.a   = r;
        e.b   = 0;
        wr_q.push_back(e);
      end
      done_q.push_back(s + 1 + m * (k + 5));
    end
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (o_done) return;
    end
    fail_now("done timeout");
  endtask

  task automatic load_random(input int k, input int m);
    for (int j = 0; j < k; j++) node_mem[j] = DW'($urandom_range(0, 255));
    for (int j = 0; j < k * m; j++) wegt_mem[j] = DW'($urandom_range(0, 255));
  endtask

  task automatic chk_reset();
    chk("rst idle", 64'(o_idle), 64'd1);
    chk("rst running", 64'(o_running), 64'd0);
    chk("rst done", 64'(o_done), 64'd0);
    chk("rst node_ce", 64'(o_node_ce), 64'd0);
    chk("rst wegt_ce", 64'(o_wegt_ce), 64'd0);
    chk("rst node_addr", 64'(o_node_addr), 64'd0);
    chk("rst wegt_addr", 64'(o_wegt_addr), 64'd0);
    chk("rst core_run", 64'(o_core_run), 64'd0);
    chk("rst core_valid", 64'(o_core_valid), 64'd0);
    chk("rst core_node", 64'(o_core_node), 64'd0);
    chk("rst core_wegt", 64'(o_core_wegt), 64'd0);
    chk("rst res_we", 64'(o_res_we), 64'd0);
    chk("rst res_addr", 64'(o_res_addr), 64'd0);
    chk("rst res_data", 64'(o_res_data), 64'd0);
  endtask

  initial begin
    int s, k, m;
    reset_n = 1'b0;
    i_start = 1'b0;
    i_num_k = '0;
    i_num_m = '0;
    #1;
    chk_reset();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // K=4, M=1: 1*5+2*6+3*7+4*8 = 70
    for (int j = 0; j < 4; j++) begin
      node_mem[j] = DW'(j + 1);
      wegt_mem[j] = DW'(j + 5);
    end
    start_run(4, 1, s);
    wait_done(40);
    chk("t1 result", 64'(last_wr_data), 64'd70);

    // K=3, M=2: rows sum to 6 and 15
    for (int j = 0; j < 3; j++) node_mem[j] = 8'd1;
    for (int j = 0; j < 6; j++) wegt_mem[j] = DW'(j + 1);
    start_run(3, 2, s);
    wait_done(40);
    chk("t2 last result", 64'(last_wr_data), 64'd15);

    // Full-scale operands: 2*255*255 = 130050
    for (int j = 0; j < 2; j++) begin
      node_mem[j] = 8'hff;
      wegt_mem[j] = 8'hff;
    end
    start_run(2, 1, s);
    wait_done(40);
    chk("t3 result", 64'(last_wr_data), 64'd130050);

    start_run(0, 3, s);
    wait_done(10);

    // Start pulsed mid-ISSUE is ignored, then a back-to-back start right after done
    load_random(5, 2);
    start_run(5, 2, s);
    @(negedge clk);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    wait_done(40);
    load_random(3, 2);
    start_run(3, 2, s);
    wait_done(40);

    // Reset in the WAIT phase of row 1 of a K=4, M=3 run
    load_random(4, 3);
    start_run(4, 3, s);
    while (cyc < s + 2 * 4 + 8) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk_reset();
    ce_q.delete();
    wr_q.delete();
    run_q.delete();
    done_q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    load_random(4, 3);
    start_run(4, 3, s);
    wait_done(60);

    for (int t = 0; t < 8; t++) begin
      k = $urandom_range(0, 8);
      m = $urandom_range(1, 4);
      load_random(k, m);
      start_run(k, m, s);
      wait_done(m * (k + 5) + 20);
    end

    repeat (5) @(negedge clk);
    chk("ce queue empty", 64'(ce_q.size()), 64'd0);
    chk("write queue empty", 64'(wr_q.size()), 64'd0);
    chk("run queue empty", 64'(run_q.size()), 64'd0);
    chk("done queue empty", 64'(done_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
